// File: rtl/switch_conditioner_341452019534398035.sv
// Debounces a 7-bit DIP switch bus: 2-flop sync, shared sample prescaler, per-bit qualification counters.
// Define SWCOND_EDGE_EN to build the registered rise/fall/changed pulse outputs; otherwise they are tied to 0.
module switch_conditioner_341452019534398035 #(
    parameter int TICK_LOG2    = 8,
    parameter int STABLE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sw_raw,
    output logic [6:0] sw_stable,
    output logic [6:0] sw_rise,
    output logic [6:0] sw_fall,
    output logic       sw_changed,
    output logic       sample_tick
);

    localparam logic [2:0] LP_LAST = 3'(STABLE_TICKS - 1);

    logic [6:0]           r_sync_p0;
    logic [6:0]           r_sync_p1;
    logic [TICK_LOG2-1:0] r_presc;
    logic                 r_tick;
    logic [2:0]           r_cnt [7];
    logic [2:0]           w_cnt_nxt [7];
    logic [6:0]           r_stable;
    logic [6:0]           w_stable_nxt;

    // Synchronizer stage boundary: pads -> r_sync_p0 -> r_sync_p1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= sw_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Tick is registered, so it is high in the cycle after the prescaler reaches all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= &r_presc;
        end
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        for (int i = 0; i < 7; i++) begin
            if (r_tick) begin
                if (r_sync_p1[i] == r_stable[i]) begin
                    w_cnt_nxt[i] = 3'd0;
                end else if (r_cnt[i] == LP_LAST) begin
                    w_stable_nxt[i] = r_sync_p1[i];
                    w_cnt_nxt[i]    = 3'd0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 3'd1;
                end
            end
        end
    end

    // Qualification stage boundary: counters and accepted levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                r_cnt[i] <= 3'd0;
            end
            r_stable <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

`ifdef SWCOND_EDGE_EN
    logic [6:0] r_rise;
    logic [6:0] r_fall;
    logic       r_changed;

    // Edge stage boundary: pulses share the clock edge that updates r_stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_rise    <= w_stable_nxt & ~r_stable;
            r_fall    <= ~w_stable_nxt & r_stable;
            r_changed <= |(w_stable_nxt ^ r_stable);
        end
    end

    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_changed;
`else
    assign sw_rise    = '0;
    assign sw_fall    = '0;
    assign sw_changed = 1'b0;
`endif

    assign sw_stable   = r_stable;
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_switch_conditioner_341452019534398035.sv
// Directed bench for the switch conditioner with TICK_LOG2=4, STABLE_TICKS=4.
// Pulse expectations follow SWCOND_EDGE_EN: with it undefined every pulse must stay 0.
module tb_switch_conditioner_341452019534398035;

`ifdef SWCOND_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [6:0] sw_raw;
    logic [6:0] sw_stable;
    logic [6:0] sw_rise;
    logic [6:0] sw_fall;
    logic       sw_changed;
    logic       sample_tick;

    int checks = 0;
    int errors = 0;
    int cyc;

    switch_conditioner_341452019534398035 #(
        .TICK_LOG2   (4),
        .STABLE_TICKS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed),
        .sample_tick(sample_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; edge N updates outputs seen at the following negedge
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_cycle(input logic [6:0] es, input logic [6:0] er,
                               input logic [6:0] ef, input logic ec);
        logic et;
        et = (cyc % 16 == 0);
        checks++;
        if (sample_tick !== et) begin
            errors++;
            $display("FAIL tick cyc=%0d got %b exp %b", cyc, sample_tick, et);
        end
        checks++;
        if (sw_stable !== es) begin
            errors++;
            $display("FAIL stable cyc=%0d got %h exp %h", cyc, sw_stable, es);
        end
        checks++;
        if (sw_rise !== er) begin
            errors++;
            $display("FAIL rise cyc=%0d got %h exp %h", cyc, sw_rise, er);
        end
        checks++;
        if (sw_fall !== ef) begin
            errors++;
            $display("FAIL fall cyc=%0d got %h exp %h", cyc, sw_fall, ef);
        end
        checks++;
        if (sw_changed !== ec) begin
            errors++;
            $display("FAIL changed cyc=%0d got %b exp %b", cyc, sw_changed, ec);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        sw_raw = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({sw_stable, sw_rise, sw_fall, sw_changed, sample_tick} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {sw_stable, sw_rise, sw_fall, sw_changed, sample_tick});
        end
        rst = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            check_cycle(7'h00, 7'h00, 7'h00, 1'b0);
        end
    endtask

    task automatic test_single_rise();
        while (cyc < 258) begin
            if (cyc == 200) sw_raw = 7'h41;
            @(negedge clk);
            check_cycle((cyc >= 257) ? 7'h41 : 7'h00,
                        (EDGE_EN && cyc == 257) ? 7'h41 : 7'h00,
                        7'h00,
                        EDGE_EN && cyc == 257);
        end
    endtask

    task automatic test_glitch();
        while (cyc < 370) begin
            if (cyc == 260) sw_raw = 7'h49;
            if (cyc == 295) sw_raw = 7'h41;
            if (cyc == 310) sw_raw = 7'h49;
            @(negedge clk);
            check_cycle((cyc >= 369) ? 7'h49 : 7'h41,
                        (EDGE_EN && cyc == 369) ? 7'h08 : 7'h00,
                        7'h00,
                        EDGE_EN && cyc == 369);
        end
    endtask

    task automatic test_fall_all();
        logic [6:0] es;
        while (cyc < 498) begin
            if (cyc == 372) sw_raw = 7'h7F;
            if (cyc == 440) sw_raw = 7'h00;
            @(negedge clk);
            es = (cyc >= 497) ? 7'h00 : (cyc >= 433) ? 7'h7F : 7'h49;
            check_cycle(es,
                        (EDGE_EN && cyc == 433) ? 7'h36 : 7'h00,
                        (EDGE_EN && cyc == 497) ? 7'h7F : 7'h00,
                        EDGE_EN && (cyc == 433 || cyc == 497));
        end
    endtask

    task automatic test_reset_mid();
        while (cyc < 550) begin
            if (cyc == 500) sw_raw = 7'h01;
            @(negedge clk);
            check_cycle(7'h00, 7'h00, 7'h00, 1'b0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sw_stable, sw_rise, sw_fall, sw_changed, sample_tick} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0",
                     {sw_stable, sw_rise, sw_fall, sw_changed, sample_tick});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (cyc < 66) begin
            @(negedge clk);
            check_cycle((cyc >= 65) ? 7'h01 : 7'h00,
                        (EDGE_EN && cyc == 65) ? 7'h01 : 7'h00,
                        7'h00,
                        EDGE_EN && cyc == 65);
        end
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = 7'h00;
        test_reset();
        test_single_rise();
        test_glitch();
        test_fall_all();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_conditioner_341452019534398035.md
SWITCH_CONDITIONER_341452019534398035 -- requirements
Module: switch_conditioner_341452019534398035

Interface
REQ-001 SHALL have parameter TICK_LOG2, default 8: sample-tick period is 2^TICK_LOG2 clk cycles (legal 2..16).
REQ-002 SHALL have parameter STABLE_TICKS, default 4: consecutive disagreeing ticks needed to accept a new level (legal 1..7).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sw_raw, input, 7 bits: unsynchronised DIP switch levels from the pads.
REQ-006 SHALL have port sw_stable, output, 7 bits: debounced switch levels, which feed the display core's dip_switch bus.
REQ-007 SHALL have port sw_rise, output, 7 bits: one-cycle pulse per bit when sw_stable goes 0->1.
REQ-008 SHALL have port sw_fall, output, 7 bits: one-cycle pulse per bit when sw_stable goes 1->0.
REQ-009 SHALL have port sw_changed, output, 1 bit: one-cycle pulse when any bit of sw_stable changes.
REQ-010 SHALL have port sample_tick, output, 1 bit: registered prescaler tick, for observation.

Function
REQ-011 SHALL pass each sw_raw bit through a two-flop synchronizer (sw_sync); nothing downstream uses sw_raw directly.
REQ-012 SHALL run a free-running TICK_LOG2-bit prescaler and pulse sample_tick for 1 cycle every 2^TICK_LOG2 cycles; first pulse at cycle 2^TICK_LOG2 after reset release.
REQ-013 SHALL keep a 3-bit counter cnt[i] per bit, updated only in sample_tick cycles.
REQ-014 SHALL, at a tick where sw_sync[i]==sw_stable[i], clear cnt[i] (a glitch restarts qualification).
REQ-015 SHALL, at a tick where sw_sync[i]!=sw_stable[i] and cnt[i]<STABLE_TICKS-1, increment cnt[i].
REQ-016 SHALL, at a tick where sw_sync[i]!=sw_stable[i] and cnt[i]==STABLE_TICKS-1, load sw_stable[i]<=sw_sync[i] and clear cnt[i].
REQ-017 SHALL, with STABLE_TICKS=1, accept at the first disagreeing tick.
REQ-018 SHALL update sw_stable, sw_rise, sw_fall and sw_changed in the same clock edge, all registered; each pulse lasts exactly 1 cycle.
REQ-019 SHALL update all qualifying bits at the same tick together; sw_changed is a single 1-cycle pulse for that tick.
REQ-020 SHALL hold sw_stable unchanged and keep all pulses low in non-tick cycles.
REQ-021 SHALL have latency from a clean sw_raw edge to sw_stable of 2 sync cycles plus STABLE_TICKS ticks (worst case 2 + STABLE_TICKS*2^TICK_LOG2 cycles).
REQ-022 SHALL keep the prescaler wrapping silently from all-ones to 0; cnt[i] never exceeds STABLE_TICKS-1.

Reset
REQ-023 SHALL, while rst=1, asynchronously force sw_sync, prescaler, every cnt[i], sw_stable, sw_rise, sw_fall, sw_changed and sample_tick to 0.
REQ-024 SHALL, on rst asserted mid-qualification, discard the partial count; after release, a switch held at 1 is accepted after a full STABLE_TICKS ticks and produces one sw_rise pulse.

Configuration
REQ-025 SHALL, with macro SWCOND_EDGE_EN defined, implement sw_rise, sw_fall and sw_changed as in REQ-018/019.
REQ-026 SHALL, with SWCOND_EDGE_EN undefined, tie sw_rise, sw_fall and sw_changed to constant 0 with no edge registers; sw_stable and sample_tick behave identically.

Verification (bench parameters TICK_LOG2=4, STABLE_TICKS=4, SWCOND_EDGE_EN defined unless stated)
REQ-027 SHALL cover: reset, then sw_raw=7'h00 for 200 cycles -> sw_stable=0; no rise/fall/changed pulse; sample_tick every 16 cycles, first at cycle 16.
REQ-028 SHALL cover: sw_raw 0->7'h41, held -> sw_stable=7'h41 at the 4th tick after sync; sw_rise=7'h41 and sw_changed=1 for exactly 1 cycle; sw_fall=0.
REQ-029 SHALL cover: bit3 raw high for 2 ticks, low at 3rd tick, then high again -> no change until 4 further consecutive ticks; single sw_rise[3] pulse.
REQ-030 SHALL cover: from sw_stable=7'h7F, sw_raw=7'h00 -> sw_fall=7'h7F in one cycle; sw_changed pulses once.
REQ-031 SHALL cover: rst pulse asserted 5 cycles after 3rd qualifying tick with sw_raw=7'h01 -> all outputs 0 immediately; sw_stable[0]=1 exactly 4 ticks after release.
REQ-032 SHALL cover: SWCOND_EDGE_EN undefined, repeat REQ-028 stimulus -> sw_stable=7'h41 at the same cycle; sw_rise, sw_fall and sw_changed stay 0 throughout.
